shake256_seeder: RTL and testbench

SHAKE256_SEEDER -- requirements
Module: shake256_seeder

---
 rtl/shake256_seeder.sv | 177 +++++++++++++++++
 tb/tb_shake256_seeder.sv | 430 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shake256_seeder.sv
// SHAKE256 seeding sequencer: sends length headers and seed words into keccak_top,
// then returns the requested number of byte-reversed result words to the consumer.
//
// state   | meaning
// IDLE    | waiting for start
// HDR_OUT | sending output-length header {4'h4, out_bits}
// HDR_IN  | sending input-length header {4'h8, in_bits}
// DATA    | passing seed words from host to keccak din
// COLLECT | passing keccak dout words to the result stream
// FINISH  | done pulse, back to IDLE
module shake256_seeder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [27:0] in_bits,
    input  logic [27:0] out_bits,
    input  logic        abort,
    output logic        busy,
    output logic        done,
    input  logic        seed_valid,
    output logic        seed_ready,
    input  logic [31:0] seed_data,
    output logic        k_din_valid,
    input  logic        k_din_ready,
    output logic [31:0] k_din,
    input  logic        k_dout_valid,
    output logic        k_dout_ready,
    input  logic [31:0] k_dout,
    output logic        k_force_done,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_data
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        HDR_OUT = 3'd1,
        HDR_IN  = 3'd2,
        DATA    = 3'd3,
        COLLECT = 3'd4,
        FINISH  = 3'd5
    } state_t;

    state_t      state;
    logic [27:0] in_bits_q;
    logic [27:0] out_bits_q;
    logic [23:0] in_words;
    logic [23:0] out_words;
    logic [23:0] cnt;
    logic [28:0] in_sum;
    logic [28:0] out_sum;
    logic        din_hs;
    logic        res_hs;

    assign in_sum  = {1'b0, in_bits} + 29'd31;
    assign out_sum = {1'b0, out_bits} + 29'd31;
    assign din_hs  = k_din_valid & k_din_ready;
    assign res_hs  = res_valid & res_ready;

    // Stream steering; abort masks every valid/ready so no handshake lands that cycle.
    always_comb begin
        k_din        = 32'h0;
        k_din_valid  = 1'b0;
        seed_ready   = 1'b0;
        res_valid    = 1'b0;
        k_dout_ready = 1'b0;
        res_data     = 32'h0;
        case (state)
            HDR_OUT: begin
                k_din       = {4'h4, out_bits_q};
                k_din_valid = ~abort;
            end
            HDR_IN: begin
                k_din       = {4'h8, in_bits_q};
                k_din_valid = ~abort;
            end
            DATA: begin
                k_din       = seed_data;
                k_din_valid = seed_valid & ~abort;
                seed_ready  = k_din_ready & ~abort;
            end
            COLLECT: begin
                res_valid    = k_dout_valid & ~abort;
                k_dout_ready = res_ready & ~abort;
                res_data     = {k_dout[7:0], k_dout[15:8], k_dout[23:16], k_dout[31:24]};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            in_bits_q    <= 28'h0;
            out_bits_q   <= 28'h0;
            in_words     <= 24'h0;
            out_words    <= 24'h0;
            cnt          <= 24'h0;
            busy         <= 1'b0;
            done         <= 1'b0;
            k_force_done <= 1'b0;
        end else begin
            done         <= 1'b0;
            k_force_done <= 1'b0;
            if (abort && state != IDLE) begin
                state        <= IDLE;
                busy         <= 1'b0;
                cnt          <= 24'h0;
                k_force_done <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            in_bits_q  <= in_bits;
                            out_bits_q <= out_bits;
                            in_words   <= in_sum[28:5];
                            out_words  <= out_sum[28:5];
                            cnt        <= 24'h0;
                            busy       <= 1'b1;
                            state      <= HDR_OUT;
                        end
                    end
                    HDR_OUT: begin
                        if (din_hs) state <= HDR_IN;
                    end
                    HDR_IN: begin
                        if (din_hs) begin
                            if (in_words != 24'h0) begin
                                state <= DATA;
                            end else if (out_words != 24'h0) begin
                                state <= COLLECT;
                            end else begin
                                state <= FINISH;
                                done  <= 1'b1;
                            end
                        end
                    end
                    DATA: begin
                        if (din_hs) begin
                            if (cnt == in_words - 24'd1) begin
                                cnt <= 24'h0;
                                if (out_words != 24'h0) begin
                                    state <= COLLECT;
                                end else begin
                                    state <= FINISH;
                                    done  <= 1'b1;
                                end
                            end else begin
                                cnt <= cnt + 24'd1;
                            end
                        end
                    end
                    COLLECT: begin
                        if (res_hs) begin
                            if (cnt == out_words - 24'd1) begin
                                cnt   <= 24'h0;
                                state <= FINISH;
                                done  <= 1'b1;
                            end else begin
                                cnt <= cnt + 24'd1;
                            end
                        end
                    end
                    FINISH: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_shake256_seeder.sv
// Bench for shake256_seeder: acts as host, keccak core and consumer, and checks
// streamed words against queued expectations.
module tb_shake256_seeder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [27:0] in_bits = 28'h0;
    logic [27:0] out_bits = 28'h0;
    logic        abort = 1'b0;
    logic        busy;
    logic        done;
    logic        seed_valid = 1'b0;
    logic        seed_ready;
    logic [31:0] seed_data = 32'h0;
    logic        k_din_valid;
    logic        k_din_ready = 1'b0;
    logic [31:0] k_din;
    logic        k_dout_valid = 1'b0;
    logic        k_dout_ready;
    logic [31:0] k_dout = 32'h0;
    logic        k_force_done;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [31:0] res_data;

    shake256_seeder dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_bits(in_bits), .out_bits(out_bits),
        .abort(abort), .busy(busy), .done(done),
        .seed_valid(seed_valid), .seed_ready(seed_ready), .seed_data(seed_data),
        .k_din_valid(k_din_valid), .k_din_ready(k_din_ready), .k_din(k_din),
        .k_dout_valid(k_dout_valid), .k_dout_ready(k_dout_ready), .k_dout(k_dout),
        .k_force_done(k_force_done),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    logic [31:0] exp_din[$];
    logic [31:0] exp_res[$];
    logic [31:0] seed_q[$];
    logic [31:0] dout_q[$];
    bit drv_en = 1'b0;
    bit rnd = 1'b0;
    int done_cnt = 0;
    int force_cnt = 0;
    int seed_hs = 0;
    int res_hs = 0;
    int din_job = 0;
    bit saw_seed_ready = 1'b0;
    bit prev_stall = 1'b0;
    bit prev_done = 1'b0;
    logic [31:0] prev_din = 32'h0;

    // Host / keccak / consumer models update their outputs just after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            seed_valid   = drv_en && seed_q.size() > 0 && (!rnd || $urandom_range(0, 2) != 0);
            seed_data    = seed_q.size() > 0 ? seed_q[0] : 32'h0;
            k_din_ready  = drv_en && (!rnd || $urandom_range(0, 2) != 0);
            k_dout_valid = drv_en && dout_q.size() > 0 && (!rnd || $urandom_range(0, 2) != 0);
            k_dout       = dout_q.size() > 0 ? dout_q[0] : 32'h0;
            res_ready    = drv_en && (!rnd || $urandom_range(0, 2) != 0);
        end
    end

    // Scoreboard: sampled mid-cycle, each handshake pops and compares the expected word.
    initial begin
        logic [31:0] w;
        forever begin
            @(negedge clk);
            if (seed_ready) saw_seed_ready = 1'b1;
            if (k_force_done) force_cnt++;
            if (done) begin
                done_cnt++;
                total++;
                if (prev_done) begin
                    bad++;
                    $display("FAIL done_width: done high two cycles, want one");
                end
            end
            prev_done = done;
            if (prev_stall) begin
                total++;
                if (k_din_valid !== 1'b1 || k_din !== prev_din) begin
                    bad++;
                    $display("FAIL hdr_hold: k_din=%h valid=%b, want %h valid=1", k_din, k_din_valid, prev_din);
                end
            end
            prev_stall = rst_n && !abort && k_din_valid && !k_din_ready && din_job < 2;
            prev_din = k_din;
            if (k_din_valid && k_din_ready) begin
                din_job++;
                total++;
                if (exp_din.size() == 0) begin
                    bad++;
                    $display("FAIL din_extra: got %h, want no word", k_din);
                end else begin
                    w = exp_din.pop_front();
                    if (k_din !== w) begin
                        bad++;
                        $display("FAIL din_word: got %h, want %h", k_din, w);
                    end
                end
            end
            if (seed_valid && seed_ready) begin
                seed_hs++;
                if (seed_q.size() > 0) void'(seed_q.pop_front());
            end
            if (k_dout_valid && k_dout_ready && dout_q.size() > 0) void'(dout_q.pop_front());
            if (res_valid && res_ready) begin
                res_hs++;
                total++;
                if (exp_res.size() == 0) begin
                    bad++;
                    $display("FAIL res_extra: got %h, want no word", res_data);
                end else begin
                    w = exp_res.pop_front();
                    if (res_data !== w) begin
                        bad++;
                        $display("FAIL res_word: got %h, want %h", res_data, w);
                    end
                end
            end
        end
    end

    task automatic setup_job(input logic [27:0] ib, input logic [27:0] ob, input bit fixed_first);
        int ni;
        int no;
        logic [31:0] w;
        ni = (int'(ib) + 31) / 32;
        no = (int'(ob) + 31) / 32;
        din_job = 0;
        exp_din.push_back({4'h4, ob});
        exp_din.push_back({4'h8, ib});
        for (int i = 0; i < ni; i++) begin
            w = $urandom;
            seed_q.push_back(w);
            exp_din.push_back(w);
        end
        for (int i = 0; i < no; i++) begin
            if (fixed_first && i == 0) begin
                dout_q.push_back(32'h11223344);
                exp_res.push_back(32'h44332211);
            end else begin
                w = $urandom;
                dout_q.push_back(w);
                exp_res.push_back({w[7:0], w[15:8], w[23:16], w[31:24]});
            end
        end
        @(posedge clk);
        #1;
        start = 1'b1;
        in_bits = ib;
        out_bits = ob;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit to);
        int base;
        base = done_cnt;
        to = 1'b1;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            if (done_cnt > base) begin
                to = 1'b0;
                break;
            end
        end
        #1;
    endtask

    task automatic flush_queues();
        exp_din.delete();
        exp_res.delete();
        seed_q.delete();
        dout_q.delete();
    endtask

    task automatic test_reset();
        #2;
        total++;
        if ({busy, done, k_force_done, k_din_valid, seed_ready, k_dout_ready, res_valid} !== 7'b0) begin
            bad++;
            $display("FAIL reset_ctl: got %b, want 0000000",
                     {busy, done, k_force_done, k_din_valid, seed_ready, k_dout_ready, res_valid});
        end
        total++;
        if (k_din !== 32'h0) begin
            bad++;
            $display("FAIL reset_kdin: got %h, want 00000000", k_din);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drv_en = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        @(negedge clk);
        total++;
        if (k_force_done !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL idle_abort: force=%b busy=%b, want 0 0", k_force_done, busy);
        end
    endtask

    task automatic test_basic();
        bit to;
        int d0;
        int s0;
        int r0;
        d0 = done_cnt;
        s0 = seed_hs;
        r0 = res_hs;
        setup_job(28'd320, 28'd3576, 1'b1);
        wait_done(2000, to);
        total++;
        if (to) begin
            bad++;
            $display("FAIL basic_timeout: no done, want done");
        end
        total++;
        if (seed_hs - s0 != 10 || res_hs - r0 != 112) begin
            bad++;
            $display("FAIL basic_counts: seeds=%0d res=%0d, want 10 112", seed_hs - s0, res_hs - r0);
        end
        total++;
        if (exp_din.size() != 0 || exp_res.size() != 0) begin
            bad++;
            $display("FAIL basic_left: din=%0d res=%0d, want 0 0", exp_din.size(), exp_res.size());
        end
        @(negedge clk);
        total++;
        if (done_cnt - d0 != 1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL basic_done: pulses=%0d busy=%b, want 1 0", done_cnt - d0, busy);
        end
    endtask

    task automatic test_zero_in();
        bit to;
        int r0;
        r0 = res_hs;
        saw_seed_ready = 1'b0;
        setup_job(28'd0, 28'd64, 1'b0);
        wait_done(500, to);
        total++;
        if (to || res_hs - r0 != 2) begin
            bad++;
            $display("FAIL zero_in: timeout=%b res=%0d, want 0 2", to, res_hs - r0);
        end
        total++;
        if (saw_seed_ready !== 1'b0) begin
            bad++;
            $display("FAIL zero_in_seed_ready: got 1, want 0");
        end
        total++;
        if (exp_din.size() != 0 || exp_res.size() != 0) begin
            bad++;
            $display("FAIL zero_in_left: din=%0d res=%0d, want 0 0", exp_din.size(), exp_res.size());
        end
    endtask

    task automatic test_stall();
        bit to;
        int s0;
        logic [27:0] obs[3] = '{28'd64, 28'd100, 28'd1};
        rnd = 1'b1;
        for (int j = 0; j < 3; j++) begin
            s0 = seed_hs;
            setup_job(28'd33, obs[j], 1'b0);
            wait_done(3000, to);
            total++;
            if (to || seed_hs - s0 != 2) begin
                bad++;
                $display("FAIL stall_seeds: timeout=%b seeds=%0d, want 0 2", to, seed_hs - s0);
            end
            total++;
            if (exp_din.size() != 0 || exp_res.size() != 0) begin
                bad++;
                $display("FAIL stall_left: din=%0d res=%0d, want 0 0", exp_din.size(), exp_res.size());
            end
        end
        rnd = 1'b0;
    endtask

    task automatic test_abort();
        bit to;
        int d0;
        int f0;
        int r0;
        int n;
        d0 = done_cnt;
        f0 = force_cnt;
        r0 = res_hs;
        setup_job(28'd320, 28'd3576, 1'b0);
        n = 0;
        while (res_hs - r0 < 5 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        #1;
        abort = 1'b1;
        @(negedge clk);
        total++;
        if ({k_din_valid, seed_ready, k_dout_ready, res_valid} !== 4'b0) begin
            bad++;
            $display("FAIL abort_drop: got %b, want 0000", {k_din_valid, seed_ready, k_dout_ready, res_valid});
        end
        @(posedge clk);
        #1;
        abort = 1'b0;
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || k_force_done !== 1'b1) begin
            bad++;
            $display("FAIL abort_next: busy=%b force=%b, want 0 1", busy, k_force_done);
        end
        @(negedge clk);
        total++;
        if (k_force_done !== 1'b0 || force_cnt - f0 != 1 || done_cnt != d0 || res_hs - r0 != 5) begin
            bad++;
            $display("FAIL abort_pulse: force=%b pulses=%0d dones=%0d res=%0d, want 0 1 0 5",
                     k_force_done, force_cnt - f0, done_cnt - d0, res_hs - r0);
        end
        flush_queues();
        setup_job(28'd64, 28'd64, 1'b0);
        wait_done(500, to);
        total++;
        if (to || exp_din.size() != 0 || exp_res.size() != 0) begin
            bad++;
            $display("FAIL abort_rerun: timeout=%b din=%0d res=%0d, want 0 0 0", to, exp_din.size(), exp_res.size());
        end
    endtask

    task automatic test_reset_mid();
        int d0;
        int f0;
        int s0;
        int n;
        d0 = done_cnt;
        f0 = force_cnt;
        s0 = seed_hs;
        setup_job(28'd320, 28'd64, 1'b0);
        n = 0;
        while (seed_hs - s0 < 3 && n < 500) begin
            @(posedge clk);
            n++;
        end
        #1;
        rst_n = 1'b0;
        #1;
        total++;
        if ({busy, done, k_force_done, k_din_valid, seed_ready, k_dout_ready, res_valid} !== 7'b0
            || k_din !== 32'h0) begin
            bad++;
            $display("FAIL rst_mid: ctl=%b k_din=%h, want 0 00000000",
                     {busy, done, k_force_done, k_din_valid, seed_ready, k_dout_ready, res_valid}, k_din);
        end
        flush_queues();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (busy !== 1'b0 || done_cnt != d0 || force_cnt != f0) begin
            bad++;
            $display("FAIL rst_release: busy=%b dones=%0d forces=%0d, want 0 0 0",
                     busy, done_cnt - d0, force_cnt - f0);
        end
    endtask

    task automatic test_busy_start();
        bit to;
        int s0;
        int r0;
        s0 = seed_hs;
        r0 = res_hs;
        setup_job(28'd320, 28'd64, 1'b0);
        start = 1'b1;
        in_bits = 28'd64;
        out_bits = 28'd3576;
        repeat (4) begin
            @(negedge clk);
            total++;
            if (busy !== 1'b1) begin
                bad++;
                $display("FAIL busy_start_busy: got %b, want 1", busy);
            end
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(500, to);
        total++;
        if (to || seed_hs - s0 != 10 || res_hs - r0 != 2) begin
            bad++;
            $display("FAIL busy_start_job: timeout=%b seeds=%0d res=%0d, want 0 10 2",
                     to, seed_hs - s0, res_hs - r0);
        end
        total++;
        if (exp_din.size() != 0 || exp_res.size() != 0) begin
            bad++;
            $display("FAIL busy_start_left: din=%0d res=%0d, want 0 0", exp_din.size(), exp_res.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_in();
        test_stall();
        test_abort();
        test_reset_mid();
        test_busy_start();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
